// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode-to-execute pipeline register for the 5-stage RISC-V core.
//   It captures the regfile read operands and the decoded fields, and presents
//   them to execute one cycle later. It also does the following:
//     - Write-back bypass: a regfile write in the same cycle as the read is not lost.
//     - Load-use hazard: it detects the hazard, stalls fetch/decode and inserts a bubble.
//     - Execute flush: the decode instruction is squashed.
//     - Bubble counter: it counts load-use bubbles and saturates at all-ones.
//
// Ports
//   iclk, irst                     clock, synchronous active-high reset
//   ivalid_d, ia1_d, ia2_d, ird_d  decode valid, rs1/rs2/rd
//   irdata1_d, irdata2_d           regfile read data for rs1/rs2
//   iimm_d, ipc_d, ictrl_d         immediate, PC, opaque control bundle
//   iregwrite_d, iload_d           decode writes rd / is a load
//   iwen_w, ia3_w, iwdata3_w       write-back port (same as the regfile write)
//   iflush_e                       squash the decode instruction
//   ostall_f, ostall_d             hold the fetch PC / hold the IF-ID register
//   ovalid_e ... octrl_e           registered execute-stage fields
//   obubble_cnt                    saturating count of load-use bubbles

module id_ex_stage #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 5,
    parameter int MP_CTRL_WIDTH = 16,
    parameter int MP_CNT_WIDTH  = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid_d,
    input  logic [MP_ADDR_WIDTH-1:0] ia1_d,
    input  logic [MP_ADDR_WIDTH-1:0] ia2_d,
    input  logic [MP_ADDR_WIDTH-1:0] ird_d,
    input  logic [MP_DATA_WIDTH-1:0] irdata1_d,
    input  logic [MP_DATA_WIDTH-1:0] irdata2_d,
    input  logic [MP_DATA_WIDTH-1:0] iimm_d,
    input  logic [MP_DATA_WIDTH-1:0] ipc_d,
    input  logic [MP_CTRL_WIDTH-1:0] ictrl_d,
    input  logic                     iregwrite_d,
    input  logic                     iload_d,
    input  logic                     iwen_w,
    input  logic [MP_ADDR_WIDTH-1:0] ia3_w,
    input  logic [MP_DATA_WIDTH-1:0] iwdata3_w,
    input  logic                     iflush_e,
    output logic                     ostall_f,
    output logic                     ostall_d,
    output logic                     ovalid_e,
    output logic                     oregwrite_e,
    output logic                     oload_e,
    output logic [MP_ADDR_WIDTH-1:0] oa1_e,
    output logic [MP_ADDR_WIDTH-1:0] oa2_e,
    output logic [MP_ADDR_WIDTH-1:0] ord_e,
    output logic [MP_DATA_WIDTH-1:0] ordata1_e,
    output logic [MP_DATA_WIDTH-1:0] ordata2_e,
    output logic [MP_DATA_WIDTH-1:0] oimm_e,
    output logic [MP_DATA_WIDTH-1:0] opc_e,
    output logic [MP_CTRL_WIDTH-1:0] octrl_e,
    output logic [MP_CNT_WIDTH-1:0]  obubble_cnt
);

    logic                     byp1;
    logic                     byp2;
    logic [MP_DATA_WIDTH-1:0] op1;
    logic [MP_DATA_WIDTH-1:0] op2;
    logic                     hz;
    logic                     stall;

    // x0 is never bypassed, so a write to x0 cannot leak into a read of x0.
    assign byp1 = iwen_w && (ia3_w != '0) && (ia3_w == ia1_d);
    assign byp2 = iwen_w && (ia3_w != '0) && (ia3_w == ia2_d);
    assign op1  = byp1 ? iwdata3_w : irdata1_d;
    assign op2  = byp2 ? iwdata3_w : irdata2_d;

    // Both source addresses are compared even when rs2 is unused. This stall
    // is conservative, but it keeps the decoder out of the hazard path.
    assign hz = ovalid_e && oload_e && (ord_e != '0) && ivalid_d &&
                ((ord_e == ia1_d) || (ord_e == ia2_d));

    assign stall    = hz && !iflush_e && !irst;
    assign ostall_f = stall;
    assign ostall_d = stall;

    always_ff @(posedge iclk) begin
        if (irst || iflush_e || hz) begin
            // A reset, a flush or a load-use bubble all clear the E register.
            ovalid_e    <= 1'b0;
            oregwrite_e <= 1'b0;
            oload_e     <= 1'b0;
            oa1_e       <= '0;
            oa2_e       <= '0;
            ord_e       <= '0;
            ordata1_e   <= '0;
            ordata2_e   <= '0;
            oimm_e      <= '0;
            opc_e       <= '0;
            octrl_e     <= '0;
        end else begin
            ovalid_e    <= ivalid_d;
            oregwrite_e <= iregwrite_d && ivalid_d;
            oload_e     <= iload_d && ivalid_d;
            oa1_e       <= ia1_d;
            oa2_e       <= ia2_d;
            ord_e       <= ird_d;
            ordata1_e   <= op1;
            ordata2_e   <= op2;
            oimm_e      <= iimm_d;
            opc_e       <= ipc_d;
            octrl_e     <= ivalid_d ? ictrl_d : '0;
        end

        // A flush takes priority, so a flushed hazard is not counted.
        if (irst) begin
            obubble_cnt <= '0;
        end else if (!iflush_e && hz && (obubble_cnt != '1)) begin
            obubble_cnt <= obubble_cnt + MP_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int NW = 32;

    logic iclk = 1'b0;
    always #5 iclk = ~iclk;

    logic          irst, ivalid_d, iregwrite_d, iload_d, iwen_w, iflush_e;
    logic [AW-1:0] ia1_d, ia2_d, ird_d, ia3_w;
    logic [DW-1:0] irdata1_d, irdata2_d, iimm_d, ipc_d, iwdata3_w;
    logic [CW-1:0] ictrl_d;

    logic          ostall_f, ostall_d, ovalid_e, oregwrite_e, oload_e;
    logic [AW-1:0] oa1_e, oa2_e, ord_e;
    logic [DW-1:0] ordata1_e, ordata2_e, oimm_e, opc_e;
    logic [CW-1:0] octrl_e;
    logic [NW-1:0] obubble_cnt;

    logic          s_stall_f, s_stall_d, s_valid, s_regwrite, s_load;
    logic [AW-1:0] s_a1, s_a2, s_rd;
    logic [DW-1:0] s_d1, s_d2, s_imm, s_pc;
    logic [CW-1:0] s_ctrl;
    logic [1:0]    s_cnt;

    id_ex_stage #(.MP_DATA_WIDTH(DW), .MP_ADDR_WIDTH(AW), .MP_CTRL_WIDTH(CW),
                  .MP_CNT_WIDTH(NW)) dut (
        .iclk(iclk), .irst(irst), .ivalid_d(ivalid_d), .ia1_d(ia1_d), .ia2_d(ia2_d),
        .ird_d(ird_d), .irdata1_d(irdata1_d), .irdata2_d(irdata2_d), .iimm_d(iimm_d),
        .ipc_d(ipc_d), .ictrl_d(ictrl_d), .iregwrite_d(iregwrite_d), .iload_d(iload_d),
        .iwen_w(iwen_w), .ia3_w(ia3_w), .iwdata3_w(iwdata3_w), .iflush_e(iflush_e),
        .ostall_f(ostall_f), .ostall_d(ostall_d), .ovalid_e(ovalid_e),
        .oregwrite_e(oregwrite_e), .oload_e(oload_e), .oa1_e(oa1_e), .oa2_e(oa2_e),
        .ord_e(ord_e), .ordata1_e(ordata1_e), .ordata2_e(ordata2_e), .oimm_e(oimm_e),
        .opc_e(opc_e), .octrl_e(octrl_e), .obubble_cnt(obubble_cnt));

    // Narrow-counter instance, driven identically, to exercise saturation.
    id_ex_stage #(.MP_DATA_WIDTH(DW), .MP_ADDR_WIDTH(AW), .MP_CTRL_WIDTH(CW),
                  .MP_CNT_WIDTH(2)) dut_sat (
        .iclk(iclk), .irst(irst), .ivalid_d(ivalid_d), .ia1_d(ia1_d), .ia2_d(ia2_d),
        .ird_d(ird_d), .irdata1_d(irdata1_d), .irdata2_d(irdata2_d), .iimm_d(iimm_d),
        .ipc_d(ipc_d), .ictrl_d(ictrl_d), .iregwrite_d(iregwrite_d), .iload_d(iload_d),
        .iwen_w(iwen_w), .ia3_w(ia3_w), .iwdata3_w(iwdata3_w), .iflush_e(iflush_e),
        .ostall_f(s_stall_f), .ostall_d(s_stall_d), .ovalid_e(s_valid),
        .oregwrite_e(s_regwrite), .oload_e(s_load), .oa1_e(s_a1), .oa2_e(s_a2),
        .ord_e(s_rd), .ordata1_e(s_d1), .ordata2_e(s_d2), .oimm_e(s_imm),
        .opc_e(s_pc), .octrl_e(s_ctrl), .obubble_cnt(s_cnt));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what execute should be holding, plus the total number
    // of load-use bubbles inserted since the last reset.
    typedef struct {
        bit          valid, regwrite, load;
        bit [AW-1:0] a1, a2, rd;
        bit [DW-1:0] d1, d2, imm, pc;
        bit [CW-1:0] ctrl;
    } ex_t;

    ex_t m;
    int  nbub;
    bit  seen_stall;

    // The value the instruction should see: the newest write wins, except for x0.
    function automatic bit [DW-1:0] operand(input bit [AW-1:0] a, input bit [DW-1:0] rd_val);
        if (iwen_w && a != 0 && a == ia3_w) return iwdata3_w;
        return rd_val;
    endfunction

    // True when execute holds a load whose destination the decode instruction reads.
    function automatic bit load_use();
        return m.valid && m.load && m.rd != 0 && ivalid_d &&
               (m.rd == ia1_d || m.rd == ia2_d);
    endfunction

    task automatic check_outputs();
        chk("valid",    ovalid_e,    m.valid);
        chk("regwrite", oregwrite_e, m.regwrite);
        chk("load",     oload_e,     m.load);
        chk("a1",       oa1_e,       m.a1);
        chk("a2",       oa2_e,       m.a2);
        chk("rd",       ord_e,       m.rd);
        chk("rdata1",   ordata1_e,   m.d1);
        chk("rdata2",   ordata2_e,   m.d2);
        chk("imm",      oimm_e,      m.imm);
        chk("pc",       opc_e,       m.pc);
        chk("ctrl",     octrl_e,     m.ctrl);
        chk("bub_cnt",  obubble_cnt, 64'(nbub));
        chk("sat_cnt",  s_cnt,       64'(nbub > 3 ? 3 : nbub));
        chk("sat_valid", s_valid,    m.valid);
    endtask

    task automatic cycle();
        bit   hz, st;
        ex_t  n;
        #1;
        hz = load_use();
        st = hz && !iflush_e && !irst;
        seen_stall = ostall_f;
        chk("stall_f", ostall_f, st);
        chk("stall_d", ostall_d, st);
        chk("sat_stall", s_stall_f, st);
        n = '{default: '0};
        if (irst) nbub = 0;
        else if (iflush_e) ;
        else if (hz) nbub++;
        else begin
            n.valid    = ivalid_d;
            n.regwrite = iregwrite_d && ivalid_d;
            n.load     = iload_d && ivalid_d;
            n.a1 = ia1_d; n.a2 = ia2_d; n.rd = ird_d;
            n.d1 = operand(ia1_d, irdata1_d);
            n.d2 = operand(ia2_d, irdata2_d);
            n.imm = iimm_d; n.pc = ipc_d;
            n.ctrl = ivalid_d ? ictrl_d : '0;
        end
        @(posedge iclk);
        #1;
        m = n;
        check_outputs();
    endtask

    task automatic set_dec(input bit v, input int a1, input int a2, input int rd,
                           input bit ld, input bit rw);
        ivalid_d = v; ia1_d = AW'(a1); ia2_d = AW'(a2); ird_d = AW'(rd);
        iload_d = ld; iregwrite_d = rw;
        irdata1_d = $urandom; irdata2_d = $urandom; iimm_d = $urandom;
        ipc_d = $urandom; ictrl_d = CW'($urandom);
    endtask

    task automatic rand_dec();
        set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    endtask

    task automatic rand_wb();
        iwen_w = $urandom_range(0, 1) == 1;
        ia3_w = AW'($urandom_range(0, 7));
        iwdata3_w = $urandom;
    endtask

    initial begin
        m = '{default: '0};
        nbub = 0;
        irst = 1'b1; iflush_e = 1'b0;
        rand_dec(); rand_wb();

        // Reset with random inputs.
        cycle();
        rand_dec(); rand_wb();
        cycle();
        chk("rst_valid", ovalid_e, 0);
        chk("rst_cnt", obubble_cnt, 0);
        chk("rst_data", ordata1_e, 0);
        irst = 1'b0;

        // Write-back bypass.
        set_dec(1, 5, 6, 9, 0, 1);
        irdata1_d = 32'h11; iwen_w = 1; ia3_w = 5; iwdata3_w = 32'hAB;
        cycle();
        chk("bypass", ordata1_e, 32'hAB);
        set_dec(1, 0, 6, 9, 0, 1);
        irdata1_d = 32'h11; iwen_w = 1; ia3_w = 0; iwdata3_w = 32'hAB;
        cycle();
        chk("no_bypass_x0", ordata1_e, 32'h11);
        iwen_w = 0;

        // Load-use: load to x7, then a reader of x7 in rs2.
        set_dec(1, 1, 2, 7, 1, 1);
        cycle();
        chk("lu_load", oload_e, 1);
        chk("lu_rd", ord_e, 7);
        set_dec(1, 3, 7, 9, 0, 1);
        cycle();
        chk("lu_stall", seen_stall, 1);
        chk("lu_bubble", ovalid_e, 0);
        chk("lu_cnt", obubble_cnt, 1);
        cycle();
        chk("lu_restall", seen_stall, 0);
        chk("lu_capt", ord_e, 9);

        // No hazard: a load to x0, and a non-load to x7.
        set_dec(1, 1, 2, 0, 1, 1);
        cycle();
        set_dec(1, 0, 0, 4, 0, 1);
        cycle();
        chk("x0_nostall", seen_stall, 0);
        set_dec(1, 1, 2, 7, 0, 1);
        cycle();
        set_dec(1, 7, 7, 4, 0, 1);
        cycle();
        chk("nonload_nostall", seen_stall, 0);
        chk("nh_cnt", obubble_cnt, 1);

        // Flush in the same cycle as a hazard.
        set_dec(1, 1, 2, 7, 1, 1);
        cycle();
        set_dec(1, 7, 3, 8, 1, 1);
        iflush_e = 1;
        cycle();
        iflush_e = 0;
        chk("fl_stall", seen_stall, 0);
        chk("fl_valid", ovalid_e, 0);
        chk("fl_regwrite", oregwrite_e, 0);
        chk("fl_cnt", obubble_cnt, 1);

        // Five more bubbles take the 2-bit counter past saturation.
        for (int k = 0; k < 5; k++) begin
            set_dec(1, 1, 2, 7, 1, 1);
            cycle();
            set_dec(1, 7, 2, 3, 0, 1);
            cycle();
            cycle();
        end
        chk("sat_hold", s_cnt, 3);
        chk("sat_wide", obubble_cnt, 6);

        // Random traffic. Decode inputs are held while a stall is in effect.
        for (int i = 0; i < 3000; i++) begin
            if (!seen_stall) rand_dec();
            rand_wb();
            iflush_e = $urandom_range(0, 9) == 0;
            irst = $urandom_range(0, 99) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the 5-stage RISC-V core. Captures the two regfile read operands plus decoded fields at the end of decode and presents them to execute one cycle later. Applies a write-back bypass so a same-cycle regfile write is never lost. Detects load-use hazards, stalls fetch/decode, inserts bubbles, handles execute flushes, and counts inserted load-use bubbles.

## Interface
- MP_DATA_WIDTH, 32, operand/PC/immediate width
- MP_ADDR_WIDTH, 5, register address width
- MP_CTRL_WIDTH, 16, opaque decoded control bundle width
- MP_CNT_WIDTH, 32, bubble counter width

- iclk  in  1  clock; all state updates on rising edge
- irst  in  1  reset, synchronous, active-high
- ivalid_d  in  1  decode holds a valid instruction
- ia1_d, ia2_d, ird_d  in  MP_ADDR_WIDTH each  rs1, rs2, rd of decode instruction
- irdata1_d, irdata2_d  in  MP_DATA_WIDTH each  regfile read data for ia1_d/ia2_d
- iimm_d, ipc_d  in  MP_DATA_WIDTH each  immediate, PC
- ictrl_d  in  MP_CTRL_WIDTH  control bundle
- iregwrite_d, iload_d  in  1 each  instruction writes rd / is a load
- iwen_w  in  1  write-back write enable (same signal driving the regfile write port)
- ia3_w  in  MP_ADDR_WIDTH  write-back address
- iwdata3_w  in  MP_DATA_WIDTH  write-back data
- iflush_e  in  1  squash the decode instruction (taken branch/jump resolved in execute)
- ostall_f, ostall_d  out  1 each  hold fetch PC / hold IF-ID register
- ovalid_e, oregwrite_e, oload_e  out  1 each  execute-stage valid, rd write, load flag
- oa1_e, oa2_e, ord_e  out  MP_ADDR_WIDTH each  registered addresses (forwarding unit input)
- ordata1_e, ordata2_e, oimm_e, opc_e  out  MP_DATA_WIDTH each  registered operands
- octrl_e  out  MP_CTRL_WIDTH  registered control
- obubble_cnt  out  MP_CNT_WIDTH  count of load-use bubbles inserted

## Operation
- Bypass: operand1 = iwdata3_w if iwen_w && ia3_w!=0 && ia3_w==ia1_d, else irdata1_d; same rule for operand2 with ia2_d. Address 0 is never bypassed, so x0 always reads 0.
- Hazard: hz = ovalid_e && oload_e && ord_e!=0 && ivalid_d && (ord_e==ia1_d || ord_e==ia2_d). Both addresses are compared regardless of whether the instruction actually uses rs2; this conservative stall is intended behaviour.
- ostall_f = ostall_d = hz && !iflush_e && !irst (combinational).
- Register update, per edge, in priority order:
  1. irst: all E registers 0, obubble_cnt 0.
  2. iflush_e: insert bubble. ovalid_e, oregwrite_e, oload_e and octrl_e go to 0; other fields don't-care but zeroed. Counter unchanged.
  3. hz: insert bubble (same zeroing). obubble_cnt += 1, saturating at all-ones.
  4. Otherwise, capture the D inputs. ovalid_e <= ivalid_d. oregwrite_e and oload_e are ANDed with ivalid_d. octrl_e is zeroed when ivalid_d=0.
- A bubble never asserts oregwrite_e or oload_e.

## Timing
- Latency: D inputs to E outputs, 1 cycle.
- A stall lasts exactly one cycle per load-use pair: after the bubble, E holds no load, and the load has moved to memory, where the downstream forwarding unit covers it.
- During a stall cycle the decode inputs must be held stable by upstream. They are re-captured on the following edge, and the bypass is re-evaluated then.
- Flush and hazard in the same cycle: flush wins, no stall, counter unchanged.
- Reset asserted mid-operation clears everything on that edge. ostall is 0 while irst=1.
- Reset values: every output 0.

## Test plan
- Reset: irst=1 for 2 cycles with random inputs -> all outputs 0, obubble_cnt=0, ostall_f=0.
- Bypass: ia1_d=5, irdata1_d=0x11, iwen_w=1, ia3_w=5, iwdata3_w=0xAB -> next cycle ordata1_e=0xAB. Repeat with ia3_w=0 and ia1_d=0 -> ordata1_e=irdata1_d.
- Load-use: load to x7 captured (oload_e=1, ord_e=7). Next decode has ia2_d=7 -> ostall_f=ostall_d=1 for one cycle, next ovalid_e=0, obubble_cnt=1; held instruction is captured on the following edge.
- No hazard: same sequence with ord_e=0, or with a non-load (oload_e=0) -> no stall, counter unchanged.
- Flush vs hazard: hazard condition plus iflush_e=1 -> ostall=0, next ovalid_e=0, oregwrite_e=0, counter unchanged.
- Saturation: MP_CNT_WIDTH=2, force 5 load-use bubbles -> obubble_cnt stays 3.
